// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit ripple-carry adder with one-cycle latency and valid tracking
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid
);
  logic [WIDTH-1:0] s;
  logic             c;
  logic             co;
  always_comb begin
    s = '0;
    c = carry_in;
    for (int k = 0; k < WIDTH; k++) begin
      s[k] = a[k] ^ b[k] ^ c;
      c    = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
    end
    co = c;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      sum       <= in_valid ? s : sum;
      carry_out <= in_valid ? co : carry_out;
    end
  end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed and randomized checks of WIDTH=1 and WIDTH=8 adders against an arithmetic model
module tb_full_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       v8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       s1, co1, ov1;
  logic [7:0] s8;
  logic       co8, ov8;
  logic       m1_s, m1_c, m1_v;
  logic [7:0] m8_s;
  logic       m8_c, m8_v;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .carry_in(c1),
    .sum(s1), .carry_out(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .carry_in(c8),
    .sum(s8), .carry_out(co8), .out_valid(ov8)
  );

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge: the model follows the stated behaviour with plain addition, then outputs are compared.
  task automatic cycle(input string tag);
    logic [1:0] r1;
    logic [8:0] r8;
    @(posedge clk);
    r1 = 2'(a1) + 2'(b1) + 2'(c1);
    r8 = 9'(a8) + 9'(b8) + 9'(c8);
    if (!rst_n) begin
      {m1_c, m1_s, m1_v} = '0;
      {m8_c, m8_s, m8_v} = '0;
    end else begin
      m1_v = v1;
      m8_v = v8;
      if (v1) {m1_c, m1_s} = r1;
      if (v8) {m8_c, m8_s} = r8;
    end
    #1;
    chk({tag, ".s1"}, 9'(s1), 9'(m1_s));
    chk({tag, ".c1"}, 9'(co1), 9'(m1_c));
    chk({tag, ".v1"}, 9'(ov1), 9'(m1_v));
    chk({tag, ".s8"}, 9'(s8), 9'(m8_s));
    chk({tag, ".c8"}, 9'(co8), 9'(m8_c));
    chk({tag, ".v8"}, 9'(ov8), 9'(m8_v));
  endtask

  initial begin
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    cycle("reset");
    chk("reset.s8_zero", 9'(s8), 9'h000);
    chk("reset.v8_zero", 9'(ov8), 9'h000);
    rst_n = 1'b1;
    v8 = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    cycle("w1_11");
    chk("w1_11.lit", {7'b0, co1, s1}, 9'b10);
    chk("w1_11.vlit", 9'(ov1), 9'h001);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    cycle("w1_hold");
    chk("w1_hold.lit", {6'b0, ov1, co1, s1}, 9'b010);
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1; {a1, b1, c1} = 3'(i);
      cycle("w1_exh");
      chk("w1_exh.tt", {7'b0, co1, s1}, 9'((i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1)));
      chk("w1_exh.v", 9'(ov1), 9'h001);
    end
    v1 = 1'b0;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
    cycle("w8_wrap0");
    chk("w8_wrap0.lit", {co8, s8}, 9'h100);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    cycle("w8_allones");
    chk("w8_allones.lit", {co8, s8}, 9'h1FF);
    a8 = 8'h1E; b8 = 8'h1E; c8 = 1'b0;
    cycle("w8_3c");
    chk("w8_3c.lit", {co8, s8}, 9'h03C);
    v8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      cycle("w8_hold");
      chk("w8_hold.lit", {co8, s8}, 9'h03C);
      chk("w8_hold.v", 9'(ov8), 9'h000);
    end
    v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
    rst_n = 1'b0;
    cycle("rst_mid");
    chk("rst_mid.lit", {ov8, co8, s8}, 10'h000);
    v8 = 1'b1;
    cycle("rst_hold2");
    cycle("rst_hold3");
    rst_n = 1'b1; v8 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      cycle("rel_idle");
      chk("rel_idle.lit", {ov8, co8, s8}, 10'h000);
    end
    v8 = 1'b1; a8 = 8'h80; b8 = 8'h80; c8 = 1'b1;
    cycle("rel_first");
    chk("rel_first.lit", {ov8, co8, s8}, 10'h301);
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 19) != 0);
      v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      v8 = ($urandom_range(0, 3) != 0);
      a8 = (i % 10 == 0) ? 8'hFF : 8'($urandom);
      b8 = 8'($urandom); c8 = 1'($urandom);
      cycle("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
